// File: rtl/io_map_pkg.sv
// Shared constants and types for the io_map memory-mapped I/O hub.
package io_map_pkg;

  localparam int ADDR_BUTTON    = 0;
  localparam int ADDR_GAME_DONE = 1;
  localparam int ADDR_SEG_CLEAR = 5;
  localparam int ADDR_STATUS    = 6;
  localparam int ADDR_RAND_X    = 7;
  localparam int ADDR_RAND_Y    = 8;
  localparam int ADDR_FOOD_X    = 9;
  localparam int ADDR_FOOD_Y    = 10;

  // Sliced down to DATA_W by users; supports data words up to 64 bits.
  localparam int MAX_W = 64;
  localparam logic [MAX_W-1:0] ALL_ONES = '1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  typedef enum logic [1:0] {
    SEL_IO   = 2'd0,
    SEL_RAM  = 2'd1,
    SEL_SEGX = 2'd2,
    SEL_SEGY = 2'd3
  } rd_sel_e;

endpackage

// File: rtl/io_seg_store.sv
// Segment coordinate array: one write port, synchronous processor and display read ports.
module io_seg_store
  import io_map_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 100,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_widx,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]  i_ridx,
  input  logic [IDX_W-1:0]  i_didx,
  output logic [DATA_W-1:0] o_rdata,
  output logic [DATA_W-1:0] o_ddata
);

  localparam logic [DATA_W-1:0] ONES = ALL_ONES[DATA_W-1:0];

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_ddata;
  logic              w_rd_ok;
  logic              w_dd_ok;

  // One extra bit so a power-of-two DEPTH does not truncate to zero.
  assign w_rd_ok = {1'b0, i_ridx} < (IDX_W+1)'(DEPTH);
  assign w_dd_ok = {1'b0, i_didx} < (IDX_W+1)'(DEPTH);

  always_ff @(posedge i_clock) begin
    if (i_we) r_mem[i_widx] <= i_wdata;
  end

  always_ff @(posedge i_clock) begin
    r_rdata <= w_rd_ok ? r_mem[i_ridx] : ONES;
    if (i_reset) r_ddata <= ONES;
    else         r_ddata <= w_dd_ok ? r_mem[i_didx] : ONES;
  end

  assign o_rdata = r_rdata;
  assign o_ddata = r_ddata;

endmodule

// File: rtl/io_map.sv
// Memory-mapped I/O hub: address decode, 1-cycle read mux, segment arrays and clear engine.
// Optional IO_MAP_BTN_LATCH_EN: sticky button latch cleared by a read of address 0.
module io_map
  import io_map_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int SEG_DEPTH  = 100,
  parameter int SEG_X_BASE = 300,
  parameter int SEG_Y_BASE = 400,
  parameter int BTN_W      = 3,
  parameter int RAND_W     = 4,
  localparam int IDX_W     = $clog2(SEG_DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wren,
  input  logic [ADDR_W-1:0] address_dmem,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] q_dmem,
  output logic              ram_wen,
  input  logic [DATA_W-1:0] ram_q,
  input  logic [BTN_W-1:0]  buttons,
  input  logic [RAND_W-1:0] rand_x,
  input  logic [RAND_W-1:0] rand_y,
  output logic [DATA_W-1:0] food_x,
  output logic [DATA_W-1:0] food_y,
  output logic [DATA_W-1:0] game_done,
  input  logic [IDX_W-1:0]  disp_idx,
  output logic [DATA_W-1:0] disp_x,
  output logic [DATA_W-1:0] disp_y,
  output logic              seg_busy
);

  localparam logic [DATA_W-1:0] ONES   = ALL_ONES[DATA_W-1:0];
  localparam logic [ADDR_W-1:0] A_BTN  = ADDR_W'(ADDR_BUTTON);
  localparam logic [ADDR_W-1:0] A_GD   = ADDR_W'(ADDR_GAME_DONE);
  localparam logic [ADDR_W-1:0] A_CLR  = ADDR_W'(ADDR_SEG_CLEAR);
  localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(ADDR_STATUS);
  localparam logic [ADDR_W-1:0] A_RX   = ADDR_W'(ADDR_RAND_X);
  localparam logic [ADDR_W-1:0] A_RY   = ADDR_W'(ADDR_RAND_Y);
  localparam logic [ADDR_W-1:0] A_FX   = ADDR_W'(ADDR_FOOD_X);
  localparam logic [ADDR_W-1:0] A_FY   = ADDR_W'(ADDR_FOOD_Y);

  logic [ADDR_W-1:0] w_off_x, w_off_y;
  logic              w_in_x, w_in_y;
  logic [BTN_W-1:0]  w_btn_val;
  rd_sel_e           w_sel, r_sel;
  logic [DATA_W-1:0] w_io_val, r_io_val;
  logic [DATA_W-1:0] r_game_done, r_food_x, r_food_y;
  clr_state_e        r_state, w_state_n;
  logic [IDX_W-1:0]  r_idx, w_idx_n;
  logic              w_clr_wr, w_clearing;
  logic              w_we_x, w_we_y;
  logic [IDX_W-1:0]  w_widx_x, w_widx_y;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_rd_x, w_rd_y;

  assign w_off_x = address_dmem - ADDR_W'(SEG_X_BASE);
  assign w_off_y = address_dmem - ADDR_W'(SEG_Y_BASE);
  assign w_in_x  = (address_dmem >= ADDR_W'(SEG_X_BASE)) && (w_off_x < ADDR_W'(SEG_DEPTH));
  assign w_in_y  = (address_dmem >= ADDR_W'(SEG_Y_BASE)) && (w_off_y < ADDR_W'(SEG_DEPTH));

`ifdef IO_MAP_BTN_LATCH_EN
  logic [BTN_W-1:0] r_btn;
  // A fresh press outranks the clear-on-read so it is never lost.
  always_ff @(posedge clock) begin
    if (reset)                                 r_btn <= '0;
    else if (buttons != '0)                    r_btn <= buttons;
    else if (!wren && address_dmem == A_BTN)   r_btn <= '0;
  end
  assign w_btn_val = r_btn;
`else
  assign w_btn_val = buttons;
`endif

  // Decode doubles as the I/O-vs-RAM classification.
  always_comb begin
    w_sel    = SEL_RAM;
    w_io_val = '0;
    if (w_in_x)      w_sel = SEL_SEGX;
    else if (w_in_y) w_sel = SEL_SEGY;
    else begin
      case (address_dmem)
        A_BTN:  begin w_sel = SEL_IO; w_io_val = DATA_W'(w_btn_val); end
        A_GD:   begin w_sel = SEL_IO; w_io_val = r_game_done;        end
        A_CLR:  begin w_sel = SEL_IO; w_io_val = '0;                 end
        A_STAT: begin w_sel = SEL_IO; w_io_val = DATA_W'(w_clearing); end
        A_RX:   begin w_sel = SEL_IO; w_io_val = DATA_W'(rand_x);    end
        A_RY:   begin w_sel = SEL_IO; w_io_val = DATA_W'(rand_y);    end
        A_FX:   begin w_sel = SEL_IO; w_io_val = r_food_x;           end
        A_FY:   begin w_sel = SEL_IO; w_io_val = r_food_y;           end
        default: ;
      endcase
    end
  end

  assign ram_wen = wren && (w_sel == SEL_RAM);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_game_done <= '0;
      r_food_x    <= DATA_W'(5);
      r_food_y    <= DATA_W'(5);
      r_sel       <= SEL_IO;
      r_io_val    <= '0;
    end else begin
      if (wren && address_dmem == A_GD && r_game_done != DATA_W'(1)) r_game_done <= data;
      if (wren && address_dmem == A_FX) r_food_x <= data;
      if (wren && address_dmem == A_FY) r_food_y <= data;
      r_sel    <= w_sel;
      r_io_val <= w_io_val;
    end
  end

  always_comb begin
    case (r_sel)
      SEL_IO:   q_dmem = r_io_val;
      SEL_SEGX: q_dmem = w_rd_x;
      SEL_SEGY: q_dmem = w_rd_y;
      default:  q_dmem = ram_q;
    endcase
  end

  assign w_clr_wr   = wren && (address_dmem == A_CLR);
  assign w_clearing = (r_state == ST_CLEAR);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_CLEAR;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_n;
      r_idx   <= w_idx_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_idx_n   = r_idx;
    if (w_clr_wr) begin
      w_state_n = ST_CLEAR;
      w_idx_n   = '0;
    end else if (r_state == ST_CLEAR) begin
      if (r_idx == IDX_W'(SEG_DEPTH-1)) begin
        w_state_n = ST_IDLE;
        w_idx_n   = '0;
      end else begin
        w_idx_n = r_idx + 1'b1;
      end
    end
  end

  // The clear engine owns the write ports while active; processor writes are dropped.
  assign w_we_x   = w_clearing || (wren && w_in_x);
  assign w_we_y   = w_clearing || (wren && w_in_y);
  assign w_widx_x = w_clearing ? r_idx : w_off_x[IDX_W-1:0];
  assign w_widx_y = w_clearing ? r_idx : w_off_y[IDX_W-1:0];
  assign w_wdata  = w_clearing ? ONES : data;

  io_seg_store #(.DATA_W(DATA_W), .DEPTH(SEG_DEPTH), .IDX_W(IDX_W)) u_seg_x (
    .i_clock(clock), .i_reset(reset), .i_we(w_we_x), .i_widx(w_widx_x),
    .i_wdata(w_wdata), .i_ridx(w_off_x[IDX_W-1:0]), .i_didx(disp_idx),
    .o_rdata(w_rd_x), .o_ddata(disp_x)
  );

  io_seg_store #(.DATA_W(DATA_W), .DEPTH(SEG_DEPTH), .IDX_W(IDX_W)) u_seg_y (
    .i_clock(clock), .i_reset(reset), .i_we(w_we_y), .i_widx(w_widx_y),
    .i_wdata(w_wdata), .i_ridx(w_off_y[IDX_W-1:0]), .i_didx(disp_idx),
    .o_rdata(w_rd_y), .o_ddata(disp_y)
  );

  assign food_x    = r_food_x;
  assign food_y    = r_food_y;
  assign game_done = r_game_done;
  assign seg_busy  = w_clearing;

endmodule

// File: tb/tb_io_map.sv
// Directed self-checking bench for io_map with default parameters.
module tb_io_map;

  logic        clock = 1'b0;
  logic        reset;
  logic        wren;
  logic [11:0] address_dmem;
  logic [31:0] data;
  logic [31:0] q_dmem;
  logic        ram_wen;
  logic [31:0] ram_q;
  logic [2:0]  buttons;
  logic [3:0]  rand_x, rand_y;
  logic [31:0] food_x, food_y, game_done;
  logic [6:0]  disp_idx;
  logic [31:0] disp_x, disp_y;
  logic        seg_busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cnt;
  logic [31:0] exp_btn1, exp_btn2, exp_live1;

  io_map dut (
    .clock(clock), .reset(reset), .wren(wren), .address_dmem(address_dmem),
    .data(data), .q_dmem(q_dmem), .ram_wen(ram_wen), .ram_q(ram_q),
    .buttons(buttons), .rand_x(rand_x), .rand_y(rand_y),
    .food_x(food_x), .food_y(food_y), .game_done(game_done),
    .disp_idx(disp_idx), .disp_x(disp_x), .disp_y(disp_y), .seg_busy(seg_busy)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; wren = 1'b0; address_dmem = 12'd50; data = '0;
    ram_q = 32'h1234_5678; buttons = '0; rand_x = '0; rand_y = '0; disp_idx = 7'd42;
    tick(); tick();
    chk("rst_q_dmem", q_dmem, 32'h0);
    chk("rst_food_x", food_x, 32'd5);
    chk("rst_food_y", food_y, 32'd5);
    chk("rst_game_done", game_done, 32'd0);
    chk("rst_disp_x", disp_x, 32'hFFFF_FFFF);
    chk("rst_disp_y", disp_y, 32'hFFFF_FFFF);
    chk("rst_busy", {31'b0, seg_busy}, 32'd1);

    // Clear engine after reset release
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 200 && seg_busy; i++) begin tick(); cnt++; end
    chk("busy_cycles_reset", cnt, 32'd100);
    tick();
    chk("disp42_x", disp_x, 32'hFFFF_FFFF);
    chk("disp42_y", disp_y, 32'hFFFF_FFFF);
    disp_idx = 7'd120; tick();
    chk("disp_oob_x", disp_x, 32'hFFFF_FFFF);

    // Segment writes and readback
    wren = 1'b1; address_dmem = 12'd303; data = 32'd7; #1;
    chk("ram_wen_303", {31'b0, ram_wen}, 32'd0);
    tick();
    address_dmem = 12'd403; data = 32'd9; #1;
    chk("ram_wen_403", {31'b0, ram_wen}, 32'd0);
    tick();
    wren = 1'b0; address_dmem = 12'd303; disp_idx = 7'd3; tick();
    chk("disp3_x", disp_x, 32'd7);
    chk("disp3_y", disp_y, 32'd9);
    chk("rd_303", q_dmem, 32'd7);
    address_dmem = 12'd403; tick();
    chk("rd_403", q_dmem, 32'd9);
    wren = 1'b1; address_dmem = 12'd304; data = 32'h55; disp_idx = 7'd4; tick();
    chk("disp_same_cycle_old", disp_x, 32'hFFFF_FFFF);
    wren = 1'b0; address_dmem = 12'd50; tick();
    chk("disp_after_write", disp_x, 32'h55);

    // Map boundaries
    wren = 1'b1;
    address_dmem = 12'd299; #1; chk("ram_wen_299", {31'b0, ram_wen}, 32'd1);
    address_dmem = 12'd399; #1; chk("ram_wen_399", {31'b0, ram_wen}, 32'd0);
    address_dmem = 12'd499; #1; chk("ram_wen_499", {31'b0, ram_wen}, 32'd0);
    address_dmem = 12'd500; #1; chk("ram_wen_500", {31'b0, ram_wen}, 32'd1);
    address_dmem = 12'd2;   #1; chk("ram_wen_2",   {31'b0, ram_wen}, 32'd1);
    address_dmem = 12'd10;  #1; chk("ram_wen_10",  {31'b0, ram_wen}, 32'd0);
    wren = 1'b0; address_dmem = 12'd50; tick();

    // GAME_DONE
    wren = 1'b1; address_dmem = 12'd1; data = 32'd2; tick();
    chk("gd_write2", game_done, 32'd2);
    wren = 1'b0; tick();
    chk("gd_read2", q_dmem, 32'd2);
    wren = 1'b1; data = 32'd0; tick();
    chk("gd_write0", game_done, 32'd0);
    data = 32'd1; tick();
    chk("gd_write1", game_done, 32'd1);
    data = 32'd0; tick();
    chk("gd_sticky0", game_done, 32'd1);
    data = 32'd3; tick();
    chk("gd_sticky3", game_done, 32'd1);

    // Food, random, status, clear readback
    address_dmem = 12'd9; data = 32'd12; tick();
    chk("food_x_write", food_x, 32'd12);
    wren = 1'b0; address_dmem = 12'd10; tick();
    chk("food_y_read", q_dmem, 32'd5);
    address_dmem = 12'd9; tick();
    chk("food_x_read", q_dmem, 32'd12);
    rand_x = 4'hC; rand_y = 4'h3; address_dmem = 12'd7; tick();
    chk("rand_x_read", q_dmem, 32'h0000_000C);
    address_dmem = 12'd8; tick();
    chk("rand_y_read", q_dmem, 32'h0000_0003);
    address_dmem = 12'd6; tick();
    chk("status_idle", q_dmem, 32'd0);
    address_dmem = 12'd5; tick();
    chk("seg_clear_read", q_dmem, 32'd0);

    // Clear restart mid-game with dropped processor writes
    wren = 1'b1; address_dmem = 12'd5; data = 32'd20; #1;
    chk("ram_wen_5", {31'b0, ram_wen}, 32'd0);
    tick();
    chk("busy_after_clear_wr", {31'b0, seg_busy}, 32'd1);
    wren = 1'b0; address_dmem = 12'd6; cnt = 0;
    tick(); cnt++;
    chk("status_busy", q_dmem, 32'd1);
    tick(); tick(); tick(); cnt += 3;
    wren = 1'b1; address_dmem = 12'd310; data = 32'h77; tick(); cnt++;
    address_dmem = 12'd300; data = 32'h66; tick(); cnt++;
    wren = 1'b0; address_dmem = 12'd50;
    for (int i = 0; i < 200 && seg_busy; i++) begin tick(); cnt++; end
    chk("busy_cycles_restart", cnt, 32'd100);
    disp_idx = 7'd10; tick();
    chk("x10_cleared", disp_x, 32'hFFFF_FFFF);
    disp_idx = 7'd0; tick();
    chk("x0_write_dropped", disp_x, 32'hFFFF_FFFF);
    address_dmem = 12'd303; tick();
    chk("x3_cleared_read", q_dmem, 32'hFFFF_FFFF);

    // Buttons
`ifdef IO_MAP_BTN_LATCH_EN
    exp_btn1 = 32'd3; exp_btn2 = 32'd0; exp_live1 = 32'd0;
`else
    exp_btn1 = 32'd0; exp_btn2 = 32'd0; exp_live1 = 32'd5;
`endif
    address_dmem = 12'd50; buttons = 3'd3; tick();
    buttons = 3'd0; address_dmem = 12'd0; tick();
    chk("btn_read1", q_dmem, exp_btn1);
    tick();
    chk("btn_read2", q_dmem, exp_btn2);
    buttons = 3'd5; tick();
    chk("btn_press_on_read", q_dmem, exp_live1);
    tick();
    chk("btn_press_next", q_dmem, 32'd5);
    buttons = 3'd0; address_dmem = 12'd50; tick();

    // RAM pass-through
    wren = 1'b1; address_dmem = 12'd50; data = 32'hAB; #1;
    chk("ram_wen_50", {31'b0, ram_wen}, 32'd1);
    tick();
    wren = 1'b0; ram_q = 32'hDEAD_BEEF; tick();
    chk("ram_q_pass", q_dmem, 32'hDEAD_BEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/io_map.md
# io_map

Parametrised memory-mapped I/O hub between the processor data-memory port, data RAM, button logic, random source and VGA controller. Decodes I/O addresses, suppresses RAM writes to them, and returns a one-cycle-latency read mux aligned with the synchronous RAM. Holds the snake segment X/Y arrays in RAM-style storage with an indexed display read port instead of a flat vector. A hardware clear engine walks the arrays.

## Interface
Parameters:
- ADDR_W, 12, data-memory address width
- DATA_W, 32, data word width
- SEG_DEPTH, 100, entries per segment array; IDX_W = $clog2(SEG_DEPTH)
- SEG_X_BASE, 300, first X-array address
- SEG_Y_BASE, 400, first Y-array address
- BTN_W, 3, button code width
- RAND_W, 4, random coordinate width

Ports (one clock; reset is synchronous and active-high):
- clock  in  1  system clock (25 MHz domain)
- reset  in  1  synchronous active-high reset
- wren  in  1  processor store strobe
- address_dmem  in  ADDR_W  processor data address
- data  in  DATA_W  processor store data
- q_dmem  out  DATA_W  read data to processor, 1-cycle latency
- ram_wen  out  1  RAM write enable: wren and the address is not I/O
- ram_q  in  DATA_W  RAM read data, 1-cycle latency
- buttons  in  BTN_W  debounced button code, 0 = none
- rand_x, rand_y  in  RAND_W  LFSR outputs
- food_x, food_y  out  DATA_W  food position; reset 5
- game_done  out  DATA_W  game-over word; reset 0
- disp_idx  in  IDX_W  display segment index
- disp_x, disp_y  out  DATA_W  segment at disp_idx, 1-cycle latency; reset all-ones
- seg_busy  out  1  clear engine active; 1 after reset

## Operation
- Map: 0 BUTTON (RO), 1 GAME_DONE (RW), 5 SEG_CLEAR (WO, reads 0), 6 STATUS (RO, bit0 = seg_busy), 7/8 RAND_X/Y (RO, zero-extended), 9/10 FOOD_X/Y (RW), [SEG_X_BASE, +SEG_DEPTH) X array, [SEG_Y_BASE, +SEG_DEPTH) Y array (RW). All other addresses go to RAM.
- ram_wen = wren and the address is outside the map above.
- GAME_DONE: a write loads data. Once the value equals 1 it is sticky, and writes are ignored until reset.
- Segment write: index = address − base, written on the clock edge.
- Clear FSM, IDLE/CLEAR:
  - Reset or a write to 5 enters CLEAR with idx=0.
  - Each CLEAR cycle writes all-ones to X[idx] and Y[idx], then increments idx.
  - CLEAR returns to IDLE after idx = SEG_DEPTH−1, taking SEG_DEPTH cycles total.
  - A write to 5 during CLEAR restarts at idx=0.
  - Processor segment writes during CLEAR are dropped. Segment reads return current contents.
- Display port: disp_idx ≥ SEG_DEPTH returns all-ones. A same-cycle write and display read of one index returns the old value.

## Timing
- Read address is registered. q_dmem selects the I/O value or ram_q one cycle later, matching RAM latency.
- All register writes take effect at the edge where wren is sampled. A readback at the next address cycle sees the new value.
- Reset values: q_dmem 0, food 5/5, game_done 0, disp_x/y all-ones, seg_busy 1 (clear runs SEG_DEPTH cycles after reset release).
- seg_busy falls the cycle after the final clear write.

## Configuration
- IO_MAP_BTN_LATCH_EN defined:
  - A nonzero buttons value is captured into a sticky latch.
  - A read of address 0 returns the latch and clears it to 0 at that edge.
  - A new nonzero press in the same cycle as the clearing read wins.
- Undefined: address 0 returns the live buttons value, sampled on the read cycle.

## Structure
- io_map_pkg: address constants (ADDR_BUTTON … ADDR_FOOD_Y), FSM state typedef, all-ones constant.
- Sub-module io_seg_store: one write port, one processor read port and one display read port, all synchronous. It is instantiated twice (X, Y). The clear FSM lives in io_map.

## Test plan
- Reset, then hold 100 cycles → seg_busy=1 for exactly 100 cycles; disp_idx=42 → disp_x=disp_y=0xFFFFFFFF; food 5/5.
- Write 7 to addr 303 and 9 to addr 403 after clear → disp_idx=3 gives 7/9 next cycle; read addr 303 returns 7; ram_wen stays 0.
- Write 1 to addr 1, then write 0 → game_done stays 1. Write 2 from reset, then 0 → game_done goes 2, then 0.
- Write 20 to addr 5 mid-game, then write addr 310 at cycle 5 → write dropped; after 100 cycles X[10]=0xFFFFFFFF.
- IO_MAP_BTN_LATCH_EN defined: pulse buttons=3 for 1 cycle, read addr 0 twice → 3, then 0. Undefined: same stimulus → 0, 0.
- Write 0xAB to addr 50 → ram_wen=1; the read returns ram_q. Read addr 7 with rand_x=4'hC → 0x0000000C.
